// File: rtl/audio_frame_bridge.sv
// Moves one stereo frame at a time from the ADC FIFO through a per-channel
// processing stage and packs the two processed samples into the DAC FIFO.
module audio_frame_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int CH_WIDTH   = DATA_WIDTH / 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  adcfifo_empty,
    output logic                  adcfifo_read,
    input  logic [DATA_WIDTH-1:0] adcfifo_readdata,
    output logic [CH_WIDTH-1:0]   proc_in_data,
    output logic                  proc_in_chan,
    output logic                  proc_in_valid,
    input  logic                  proc_in_ready,
    input  logic [CH_WIDTH-1:0]   proc_out_data,
    input  logic                  proc_out_valid,
    output logic                  proc_out_ready,
    input  logic                  dacfifo_full,
    output logic                  dacfifo_write,
    output logic [DATA_WIDTH-1:0] dacfifo_writedata,
    output logic [15:0]           frame_count,
    output logic                  busy
);

    localparam int HALF = DATA_WIDTH / 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SEND_L  = 3'd3,
        ST_SEND_R  = 3'd4,
        ST_COLLECT = 3'd5,
        ST_WRITE   = 3'd6
    } state_t;

    state_t                state_r;
    state_t                state_next_s;
    logic [DATA_WIDTH-1:0] frame_r;
    logic [1:0]            count_r;
    logic [1:0]            count_next_s;
    logic [CH_WIDTH-1:0]   left_slot_r;
    logic [CH_WIDTH-1:0]   right_slot_r;
    logic [CH_WIDTH-1:0]   left_next_s;
    logic [CH_WIDTH-1:0]   right_next_s;
    logic [CH_WIDTH-1:0]   send_data_s;
    logic                  beat_s;
    logic                  wr_fire_s;

    logic                  adcfifo_read_r;
    logic                  proc_in_valid_r;
    logic                  proc_in_chan_r;
    logic [CH_WIDTH-1:0]   proc_in_data_r;
    logic                  proc_out_ready_r;
    logic                  busy_r;
    logic [15:0]           frame_count_r;
    logic [DATA_WIDTH-1:0] writedata_r;

    function automatic logic [CH_WIDTH-1:0] left_of(input logic [DATA_WIDTH-1:0] frame);
        return CH_WIDTH'(frame[DATA_WIDTH-1:HALF]);
    endfunction

    function automatic logic [CH_WIDTH-1:0] right_of(input logic [DATA_WIDTH-1:0] frame);
        return CH_WIDTH'(frame[HALF-1:0]);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] pack_frame(input logic [CH_WIDTH-1:0] left,
                                                         input logic [CH_WIDTH-1:0] right);
        return {HALF'(left), HALF'(right)};
    endfunction

    assign adcfifo_read      = adcfifo_read_r;
    assign proc_in_valid     = proc_in_valid_r;
    assign proc_in_chan      = proc_in_chan_r;
    assign proc_in_data      = proc_in_data_r;
    assign proc_out_ready    = proc_out_ready_r;
    assign busy              = busy_r;
    assign frame_count       = frame_count_r;
    assign dacfifo_writedata = writedata_r;
    // The strobe must follow the live full flag so a frame is never pushed into a full FIFO.
    assign dacfifo_write     = wr_fire_s;

    // Next-state, result-slot and outgoing-sample decode.
    always_comb begin
        beat_s       = proc_out_valid & proc_out_ready_r;
        wr_fire_s    = (state_r == ST_WRITE) & ~dacfifo_full;
        state_next_s = state_r;
        count_next_s = count_r;
        left_next_s  = left_slot_r;
        right_next_s = right_slot_r;
        send_data_s  = proc_in_data_r;

        if (state_r == ST_CAPTURE) begin
            count_next_s = 2'd0;
            left_next_s  = '0;
            right_next_s = '0;
        end else if (beat_s && (count_r == 2'd0)) begin
            count_next_s = 2'd1;
            left_next_s  = proc_out_data;
        end else if (beat_s && (count_r == 2'd1)) begin
            count_next_s = 2'd2;
            right_next_s = proc_out_data;
        end else begin
            count_next_s = count_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (!adcfifo_empty) begin
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FETCH:   state_next_s = ST_CAPTURE;
            ST_CAPTURE: state_next_s = ST_SEND_L;
            ST_SEND_L: begin
                if (proc_in_ready) begin
                    state_next_s = ST_SEND_R;
                end else begin
                    state_next_s = ST_SEND_L;
                end
            end
            ST_SEND_R: begin
                if (proc_in_ready) begin
                    state_next_s = ST_COLLECT;
                end else begin
                    state_next_s = ST_SEND_R;
                end
            end
            ST_COLLECT: begin
                if (count_next_s == 2'd2) begin
                    state_next_s = ST_WRITE;
                end else begin
                    state_next_s = ST_COLLECT;
                end
            end
            ST_WRITE: begin
                if (dacfifo_full) begin
                    state_next_s = ST_WRITE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase

        // The left sample is taken straight off the FIFO bus while the frame register loads.
        if (state_next_s == ST_SEND_R) begin
            send_data_s = right_of(frame_r);
        end else if (state_r == ST_CAPTURE) begin
            send_data_s = left_of(adcfifo_readdata);
        end else if (state_next_s == ST_SEND_L) begin
            send_data_s = left_of(frame_r);
        end else begin
            send_data_s = proc_in_data_r;
        end
    end

    // State machine, datapath registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r          <= ST_IDLE;
            frame_r          <= '0;
            count_r          <= 2'd0;
            left_slot_r      <= '0;
            right_slot_r     <= '0;
            adcfifo_read_r   <= 1'b0;
            proc_in_valid_r  <= 1'b0;
            proc_in_chan_r   <= 1'b0;
            proc_in_data_r   <= '0;
            proc_out_ready_r <= 1'b0;
            busy_r           <= 1'b0;
            frame_count_r    <= 16'd0;
            writedata_r      <= '0;
        end else begin
            state_r          <= state_next_s;
            count_r          <= count_next_s;
            left_slot_r      <= left_next_s;
            right_slot_r     <= right_next_s;
            adcfifo_read_r   <= (state_next_s == ST_FETCH);
            proc_in_valid_r  <= (state_next_s == ST_SEND_L) || (state_next_s == ST_SEND_R);
            proc_in_chan_r   <= (state_next_s == ST_SEND_R);
            proc_in_data_r   <= send_data_s;
            proc_out_ready_r <= ((state_next_s == ST_SEND_L) || (state_next_s == ST_SEND_R) ||
                                 (state_next_s == ST_COLLECT)) && (count_next_s < 2'd2);
            busy_r           <= (state_next_s != ST_IDLE);
            if (state_r == ST_CAPTURE) begin
                frame_r <= adcfifo_readdata;
            end
            // Packed word is staged on WRITE entry so it is valid alongside the strobe.
            if ((state_next_s == ST_WRITE) && (state_r != ST_WRITE)) begin
                writedata_r <= pack_frame(left_next_s, right_next_s);
            end
            if (wr_fire_s) begin
                frame_count_r <= frame_count_r + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_audio_frame_bridge.sv
// Directed bench for audio_frame_bridge: vector table of frames plus hand-written
// sequences for backpressure, DAC-full, empty FIFO, counter wrap and mid-frame reset.
module tb_audio_frame_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        adcfifo_empty;
    logic        adcfifo_read;
    logic [31:0] adcfifo_readdata = 32'd0;
    logic [15:0] proc_in_data;
    logic        proc_in_chan;
    logic        proc_in_valid;
    logic        proc_in_ready;
    logic [15:0] proc_out_data;
    logic        proc_out_valid;
    logic        proc_out_ready;
    logic        dacfifo_full;
    logic        dacfifo_write;
    logic [31:0] dacfifo_writedata;
    logic [15:0] frame_count;
    logic        busy;

    logic        proc_imm;
    logic        man_valid;
    logic [15:0] man_data;
    logic [31:0] fifo_word;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int hs_l   = 0;
    int hs_r   = 0;

    typedef struct {
        logic [31:0] frame;
        logic [31:0] exp_out;
    } vec_t;

    vec_t vecs[5];

    audio_frame_bridge dut (
        .clk               (clk),
        .reset             (reset),
        .adcfifo_empty     (adcfifo_empty),
        .adcfifo_read      (adcfifo_read),
        .adcfifo_readdata  (adcfifo_readdata),
        .proc_in_data      (proc_in_data),
        .proc_in_chan      (proc_in_chan),
        .proc_in_valid     (proc_in_valid),
        .proc_in_ready     (proc_in_ready),
        .proc_out_data     (proc_out_data),
        .proc_out_valid    (proc_out_valid),
        .proc_out_ready    (proc_out_ready),
        .dacfifo_full      (dacfifo_full),
        .dacfifo_write     (dacfifo_write),
        .dacfifo_writedata (dacfifo_writedata),
        .frame_count       (frame_count),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    // Processing stage model: either immediate +1 echo or manually driven results.
    always_comb begin
        if (proc_imm) begin
            proc_out_valid = proc_in_valid & proc_in_ready;
            proc_out_data  = proc_in_data + 16'd1;
        end else begin
            proc_out_valid = man_valid;
            proc_out_data  = man_data;
        end
    end

    // ADC FIFO read port with one-cycle latency, plus event counters.
    always @(posedge clk) begin
        if (adcfifo_read) begin
            adcfifo_readdata <= fifo_word;
            rd_cnt <= rd_cnt + 1;
        end
        if (dacfifo_write) begin
            wr_cnt <= wr_cnt + 1;
        end
        if (proc_in_valid && proc_in_ready) begin
            if (proc_in_chan) hs_r <= hs_r + 1;
            else hs_l <= hs_l + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w, output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        @(negedge clk);
        fifo_word     = w;
        adcfifo_empty = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (adcfifo_read) begin
                ok = 1'b1;
                break;
            end
        end
        adcfifo_empty = 1'b1;
    endtask

    task automatic wait_write(output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 200; i++) begin
            if (dacfifo_write) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_adcfifo_read"}, adcfifo_read, 32'd0);
        chk({tag, "_proc_in_valid"}, proc_in_valid, 32'd0);
        chk({tag, "_proc_out_ready"}, proc_out_ready, 32'd0);
        chk({tag, "_dacfifo_write"}, dacfifo_write, 32'd0);
        chk({tag, "_busy"}, busy, 32'd0);
        chk({tag, "_frame_count"}, frame_count, 32'd0);
        chk({tag, "_writedata"}, dacfifo_writedata, 32'd0);
        chk({tag, "_proc_in_data"}, proc_in_data, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          ok;
        int          n1;
        int          n2;
        int          rd0;
        int          wr0;
        int          hl0;
        int          hr0;
        bit          seen_rd;
        bit          seen_busy;
        bit          quiet;
        logic [15:0] exp_fc;

        vecs[0] = '{32'h1234_ABCD, 32'h1235_ABCE};
        vecs[1] = '{32'h0000_FFFF, 32'h0001_0000};
        vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0000};
        vecs[3] = '{32'h8000_7FFF, 32'h8001_8000};
        vecs[4] = '{32'h0F0F_F0F0, 32'h0F10_F0F1};

        reset         = 1'b1;
        adcfifo_empty = 1'b1;
        proc_in_ready = 1'b1;
        dacfifo_full  = 1'b0;
        proc_imm      = 1'b1;
        man_valid     = 1'b0;
        man_data      = 16'd0;
        fifo_word     = 32'd0;
        exp_fc        = 16'd0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        // Empty FIFO: nothing may be read and the block stays idle.
        rd0 = rd_cnt;
        seen_rd = 1'b0;
        seen_busy = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (adcfifo_read) seen_rd = 1'b1;
            if (busy) seen_busy = 1'b1;
        end
        chk("empty_no_read", seen_rd, 32'd0);
        chk("empty_not_busy", seen_busy, 32'd0);
        chk("empty_read_count", rd_cnt - rd0, 32'd0);

        // Vector table: immediate processing, FIFO never full.
        for (int i = 0; i < 5; i++) begin
            rd0 = rd_cnt;
            wr0 = wr_cnt;
            push_word(vecs[i].frame, ok, n1);
            chk("vec_read_seen", ok, 32'd1);
            wait_write(ok, n2);
            chk("vec_write_seen", ok, 32'd1);
            chk("vec_writedata", dacfifo_writedata, vecs[i].exp_out);
            chk("vec_latency", n1 + n2, 32'd6);
            @(negedge clk);
            exp_fc = exp_fc + 16'd1;
            chk("vec_frame_count", frame_count, exp_fc);
            chk("vec_reads", rd_cnt - rd0, 32'd1);
            chk("vec_writes", wr_cnt - wr0, 32'd1);
            chk("vec_idle_after", busy, 32'd0);
        end

        // Backpressure on the left sample.
        proc_in_ready = 1'b0;
        hl0 = hs_l;
        hr0 = hs_r;
        push_word(32'h1234_ABCD, ok, n1);
        chk("bp_read_seen", ok, 32'd1);
        for (int i = 0; i < 20; i++) begin
            if (proc_in_valid) break;
            @(negedge clk);
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", proc_in_valid, 32'd1);
            chk("bp_hold_data", proc_in_data, 32'h1234);
            chk("bp_hold_chan", proc_in_chan, 32'd0);
            @(negedge clk);
        end
        proc_in_ready = 1'b1;
        wait_write(ok, n2);
        chk("bp_write_seen", ok, 32'd1);
        chk("bp_writedata", dacfifo_writedata, 32'h1235_ABCE);
        @(negedge clk);
        exp_fc = exp_fc + 16'd1;
        chk("bp_frame_count", frame_count, exp_fc);
        chk("bp_left_transfers", hs_l - hl0, 32'd1);
        chk("bp_right_transfers", hs_r - hr0, 32'd1);

        // DAC FIFO full while the frame sits in WRITE.
        dacfifo_full = 1'b1;
        wr0 = wr_cnt;
        push_word(32'h0A0B_0C0D, ok, n1);
        chk("full_read_seen", ok, 32'd1);
        rd0 = rd_cnt;
        quiet = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (dacfifo_write || adcfifo_read) quiet = 1'b0;
        end
        chk("full_no_write_no_read", quiet, 32'd1);
        chk("full_busy_hold", busy, 32'd1);
        dacfifo_full = 1'b0;
        #1;
        chk("full_write_after_drop", dacfifo_write, 32'd1);
        chk("full_writedata", dacfifo_writedata, 32'h0A0C_0C0E);
        @(negedge clk);
        exp_fc = exp_fc + 16'd1;
        chk("full_single_write", wr_cnt - wr0, 32'd1);
        chk("full_frame_count", frame_count, exp_fc);
        chk("full_extra_reads", rd_cnt - rd0, 32'd1);

        // Frame counter wrap from 0xFFFF.
        force dut.frame_count_r = 16'hFFFF;
        @(negedge clk);
        release dut.frame_count_r;
        push_word(32'h0000_0001, ok, n1);
        wait_write(ok, n2);
        chk("wrap_write_seen", ok, 32'd1);
        chk("wrap_writedata", dacfifo_writedata, 32'h0001_0002);
        @(negedge clk);
        chk("wrap_frame_count", frame_count, 32'h0000);

        // Reset while COLLECT holds one result.
        proc_imm  = 1'b0;
        man_valid = 1'b0;
        push_word(32'h5555_6666, ok, n1);
        chk("mid_read_seen", ok, 32'd1);
        for (int i = 0; i < 20; i++) begin
            if (proc_in_valid) break;
            @(negedge clk);
        end
        man_data  = 16'h7777;
        man_valid = 1'b1;
        @(negedge clk);
        man_valid = 1'b0;
        @(negedge clk);
        chk("mid_collect_ready", proc_out_ready, 32'd1);
        chk("mid_collect_busy", busy, 32'd1);
        chk("mid_collect_no_valid", proc_in_valid, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("mid_reset");
        proc_imm = 1'b1;
        push_word(32'h0001_0002, ok, n1);
        wait_write(ok, n2);
        chk("post_reset_write_seen", ok, 32'd1);
        chk("post_reset_writedata", dacfifo_writedata, 32'h0002_0003);
        chk("post_reset_latency", n1 + n2, 32'd6);
        @(negedge clk);
        chk("post_reset_frame_count", frame_count, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_frame_bridge.md
AUDIO_FRAME_BRIDGE -- requirements
Module: audio_frame_bridge

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, stereo frame width; left = [DATA_WIDTH-1:DATA_WIDTH/2], right = [DATA_WIDTH/2-1:0].
REQ-002 Parameter: CH_WIDTH, default DATA_WIDTH/2, per-channel sample width.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 adcfifo_empty  in  1  ADC FIFO empty flag.
REQ-006 adcfifo_read  out  1  ADC FIFO read strobe.
REQ-007 adcfifo_readdata  in  DATA_WIDTH  ADC FIFO data, valid the cycle after adcfifo_read.
REQ-008 proc_in_data  out  CH_WIDTH  sample to processing stage (compressor).
REQ-009 proc_in_chan  out  1  channel tag of proc_in_data: 0 left, 1 right.
REQ-010 proc_in_valid / proc_in_ready  out / in  1 / 1  upstream-to-processing handshake.
REQ-011 proc_out_data  in  CH_WIDTH  processed sample.
REQ-012 proc_out_valid / proc_out_ready  in / out  1 / 1  processing-to-bridge handshake.
REQ-013 dacfifo_full  in  1  DAC FIFO full flag.
REQ-014 dacfifo_write  out  1  DAC FIFO write strobe.
REQ-015 dacfifo_writedata  out  DATA_WIDTH  packed processed frame.
REQ-016 frame_count  out  16  count of frames written to DAC FIFO.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, CAPTURE, SEND_L, SEND_R, COLLECT, WRITE.
REQ-019 IDLE -> FETCH when adcfifo_empty=0; otherwise remain.
REQ-020 FETCH: adcfifo_read=1 for exactly that one cycle; -> CAPTURE unconditionally.
REQ-021 CAPTURE: latch adcfifo_readdata into frame register; clear result count; -> SEND_L.
REQ-022 SEND_L: proc_in_valid=1, proc_in_chan=0, data=left half; on proc_in_ready=1 -> SEND_R.
REQ-023 SEND_R: proc_in_valid=1, proc_in_chan=1, data=right half; on proc_in_ready=1 -> COLLECT.
REQ-024 proc_in_data/proc_in_chan SHALL stay stable while proc_in_valid=1 and proc_in_ready=0.
REQ-025 proc_out_ready=1 in SEND_L, SEND_R, COLLECT while result count <2; 0 elsewhere.
REQ-026 Each proc_out_valid&proc_out_ready beat stores proc_out_data: first beat -> left slot, second -> right slot; count increments.
REQ-027 COLLECT -> WRITE in the cycle the count reaches 2 (including the capturing cycle's registered update).
REQ-028 WRITE: if dacfifo_full=0, dacfifo_write=1 for one cycle with {left slot, right slot}, frame_count increments, -> IDLE; if full, hold with dacfifo_write=0 (no drop).
REQ-029 frame_count SHALL wrap 0xFFFF -> 0x0000.
REQ-030 dacfifo_writedata SHALL hold its last written value outside WRITE.
REQ-031 Only one frame in flight; adcfifo_read never asserted outside FETCH, never while adcfifo_empty=1 at FETCH entry.
REQ-032 Minimum frame latency (ready/valid immediate, FIFO not full): IDLE to dacfifo_write = 6 cycles.

Reset
REQ-033 While reset=1 at a clock edge: state=IDLE; adcfifo_read, proc_in_valid, proc_out_ready, dacfifo_write, busy = 0; frame_count=0; frame/result registers and dacfifo_writedata = 0.
REQ-034 Reset mid-frame SHALL discard the in-flight frame (already-read FIFO word is lost) and resume from IDLE on first cycle after release.

Verification
REQ-035 Single frame: FIFO word 0x1234_ABCD, processing returns input+1 immediately -> one dacfifo_write of 0x1235_ABCE, frame_count=1, one adcfifo_read.
REQ-036 Backpressure: proc_in_ready low 5 cycles in SEND_L -> proc_in_data=0x1234 held stable, single transfer per channel.
REQ-037 DAC full: dacfifo_full=1 for 10 cycles at WRITE -> no write, no read; write occurs first cycle after full drops.
REQ-038 Empty FIFO: adcfifo_empty=1 100 cycles -> adcfifo_read never 1, busy=0.
REQ-039 Wrap: preload 65535 frames -> next write gives frame_count=0x0000.
REQ-040 Reset in COLLECT after one result -> outputs per REQ-033 next cycle; next frame 0x0001_0002 written correctly, no stale left sample.
